traffic_analyzer_gmii: RTL and testbench

TRAFFIC_ANALYZER_GMII -- requirements
Module: traffic_analyzer_gmii

---
 rtl/traffic_analyzer_gmii_pkg.sv | 35 +++
 rtl/traffic_analyzer_gmii_if.sv | 9 +
 rtl/traffic_analyzer_gmii_crc32.sv | 23 ++
 rtl/traffic_analyzer_gmii_defines.v | 19 +
 rtl/traffic_analyzer_gmii.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_traffic_analyzer_gmii.sv | 237 +++++++++++++++++++++++
 6 files changed

// File: rtl/traffic_analyzer_gmii_pkg.sv
// Constants, frame classes and helpers shared by the GMII traffic analyser.
package traffic_analyzer_gmii_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PREAMBLE = 2'd1;
    localparam logic [1:0] ST_DATA     = 2'd2;
    localparam logic [1:0] ST_DROP     = 2'd3;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

    localparam int DEF_MIN_FRAME_SIZE = 64;
    localparam int DEF_MAX_FRAME_SIZE = 1518;

    typedef enum logic [2:0] {
        CLS_GOOD,
        CLS_BAD_FCS,
        CLS_RUNT,
        CLS_OVERSIZE,
        CLS_ERROR
    } frame_class_e;

    // The residue constant is in normal bit order; the CRC register runs reflected.
    function automatic logic [31:0] bit_rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/traffic_analyzer_gmii_if.sv
// GMII receive bundle: the PHY side drives, the analyser listens.
interface traffic_analyzer_gmii_if;
    logic [7:0] gmii_d;
    logic       gmii_dv;
    logic       gmii_er;

    modport master (output gmii_d, output gmii_dv, output gmii_er);
    modport slave  (input  gmii_d, input  gmii_dv, input  gmii_er);
endinterface

// File: rtl/traffic_analyzer_gmii_crc32.sv
// Combinational one-byte update of the reflected Ethernet CRC-32, data LSB first.
module crc32_gmii
    import traffic_analyzer_gmii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    always_comb begin
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/traffic_analyzer_gmii_defines.v
// Shared constants for the GMII traffic analyser and the register block that will sit on top of it.
// The analyser package carries the same values; keep the two in step.
`ifndef TRAFFIC_ANALYZER_GMII_DEFINES_V
`define TRAFFIC_ANALYZER_GMII_DEFINES_V

`define TA_GMII_ST_IDLE          2'd0
`define TA_GMII_ST_PREAMBLE      2'd1
`define TA_GMII_ST_DATA          2'd2
`define TA_GMII_ST_DROP          2'd3

`define TA_GMII_PREAMBLE_BYTE    8'h55
`define TA_GMII_SFD_BYTE         8'hD5

`define TA_GMII_CRC_RESIDUE      32'hC704DD7B

`define TA_GMII_MIN_FRAME_SIZE   64
`define TA_GMII_MAX_FRAME_SIZE   1518

`endif

// File: rtl/traffic_analyzer_gmii.sv
// GMII receive traffic analyser: frames are delineated, classified and counted, with
// SFD timestamps and inter-frame gap statistics.
//
// state    | meaning
// IDLE     | waiting for data valid to rise
// PREAMBLE | consuming 0x55 bytes until the SFD
// DATA     | counting frame bytes and running the CRC
// DROP     | discarding an ignored or malformed frame until data valid falls
module traffic_analyzer_gmii
    import traffic_analyzer_gmii_pkg::*;
#(
    parameter int C_MIN_FRAME_SIZE = DEF_MIN_FRAME_SIZE,
    parameter int C_MAX_FRAME_SIZE = DEF_MAX_FRAME_SIZE
) (
    input  logic                    clk,
    input  logic                    rst,
    traffic_analyzer_gmii_if.slave  gmii,
    input  logic [47:0]             sec,
    input  logic [29:0]             nsec,
    input  logic                    enable,
    input  logic                    clear,
    output logic [31:0]             good_frames,
    output logic [31:0]             bad_fcs_frames,
    output logic [31:0]             runt_frames,
    output logic [31:0]             oversize_frames,
    output logic [31:0]             error_frames,
    output logic [63:0]             rx_bytes,
    output logic [15:0]             last_frame_size,
    output logic [47:0]             last_ts_sec,
    output logic [29:0]             last_ts_nsec,
    output logic [31:0]             last_gap,
    output logic [31:0]             min_gap,
    output logic                    frame_valid
);

    localparam logic [15:0] MIN_LEN = 16'(C_MIN_FRAME_SIZE);
    localparam logic [15:0] MAX_LEN = 16'(C_MAX_FRAME_SIZE);
    localparam logic [15:0] LEN_MAX = 16'hFFFF;
    localparam logic [31:0] GAP_MAX = 32'hFFFFFFFF;

    logic [7:0]   d_q, d_d;
    logic         dv_q, dv_d;
    logic         er_q, er_d;
    logic         in_vld_q, in_vld_d;
    logic         dvp_q, dvp_d;
    logic [1:0]   state_q, state_d;
    logic [15:0]  len_q, len_d;
    logic [31:0]  crc_q, crc_d;
    logic         err_q, err_d;
    logic [31:0]  gap_q, gap_d;
    logic         seen_q, seen_d;
    logic         pend_q, pend_d;
    frame_class_e pend_cls_q, pend_cls_d;
    logic [15:0]  pend_len_q, pend_len_d;
    logic         pend_size_q, pend_size_d;
    logic [31:0]  good_q, good_d;
    logic [31:0]  bad_fcs_q, bad_fcs_d;
    logic [31:0]  runt_q, runt_d;
    logic [31:0]  over_q, over_d;
    logic [31:0]  error_q, error_d;
    logic [63:0]  rx_bytes_q, rx_bytes_d;
    logic [15:0]  last_size_q, last_size_d;
    logic [47:0]  ts_sec_q, ts_sec_d;
    logic [29:0]  ts_nsec_q, ts_nsec_d;
    logic [31:0]  last_gap_q, last_gap_d;
    logic [31:0]  min_gap_q, min_gap_d;
    logic         fv_q, fv_d;

    logic [31:0]  crc_next;
    logic         dv_rise;
    frame_class_e cls_now;

    crc32_gmii u_crc (
        .crc_in  (crc_q),
        .data    (d_q),
        .crc_out (crc_next)
    );

    assign dv_rise = dv_q & ~dvp_q;

    always_comb begin
        if (err_q) begin
            cls_now = CLS_ERROR;
        end else if (len_q < MIN_LEN) begin
            cls_now = CLS_RUNT;
        end else if (len_q > MAX_LEN) begin
            cls_now = CLS_OVERSIZE;
        end else if (bit_rev32(crc_q) != CRC_RESIDUE) begin
            cls_now = CLS_BAD_FCS;
        end else begin
            cls_now = CLS_GOOD;
        end
    end

    always_comb begin
        d_d         = gmii.gmii_d;
        dv_d        = gmii.gmii_dv;
        er_d        = gmii.gmii_er;
        in_vld_d    = 1'b1;
        // Until the input registers hold a real sample, dv is treated as already high so a
        // frame still in flight at reset release is not mistaken for a new one.
        dvp_d       = in_vld_q ? dv_q : 1'b1;
        state_d     = state_q;
        len_d       = len_q;
        crc_d       = crc_q;
        err_d       = err_q;
        gap_d       = gap_q;
        seen_d      = seen_q;
        pend_d      = 1'b0;
        pend_cls_d  = pend_cls_q;
        pend_len_d  = pend_len_q;
        pend_size_d = pend_size_q;
        good_d      = good_q;
        bad_fcs_d   = bad_fcs_q;
        runt_d      = runt_q;
        over_d      = over_q;
        error_d     = error_q;
        rx_bytes_d  = rx_bytes_q;
        last_size_d = last_size_q;
        ts_sec_d    = ts_sec_q;
        ts_nsec_d   = ts_nsec_q;
        last_gap_d  = last_gap_q;
        min_gap_d   = min_gap_q;
        fv_d        = 1'b0;

        if (!dv_q && gap_q != GAP_MAX) begin
            gap_d = gap_q + 32'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (dv_rise) begin
                    gap_d = '0;
                    if (enable) begin
                        state_d = ST_PREAMBLE;
                        err_d   = er_q;
                        seen_d  = 1'b1;
                        if (seen_q) begin
                            last_gap_d = gap_q;
                            if (gap_q < min_gap_q) begin
                                min_gap_d = gap_q;
                            end
                        end
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_PREAMBLE: begin
                if (!dv_q) begin
                    state_d     = ST_IDLE;
                    pend_d      = 1'b1;
                    pend_cls_d  = CLS_ERROR;
                    pend_size_d = 1'b0;
                end else if (d_q == SFD_BYTE) begin
                    state_d   = ST_DATA;
                    err_d     = err_q | er_q;
                    ts_sec_d  = sec;
                    ts_nsec_d = nsec;
                    len_d     = '0;
                    crc_d     = CRC_INIT;
                end else if (d_q != PREAMBLE_BYTE) begin
                    state_d     = ST_DROP;
                    pend_d      = 1'b1;
                    pend_cls_d  = CLS_ERROR;
                    pend_size_d = 1'b0;
                end else begin
                    err_d = err_q | er_q;
                end
            end
            ST_DATA: begin
                if (dv_q) begin
                    crc_d = crc_next;
                    err_d = err_q | er_q;
                    if (len_q != LEN_MAX) begin
                        len_d = len_q + 16'd1;
                    end
                end else begin
                    state_d     = ST_IDLE;
                    pend_d      = 1'b1;
                    pend_cls_d  = cls_now;
                    pend_len_d  = len_q;
                    pend_size_d = 1'b1;
                end
            end
            default: begin
                if (!dv_q) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        // Statistics stage: one cycle behind classification; clear wins over a pending frame.
        if (clear) begin
            good_d      = '0;
            bad_fcs_d   = '0;
            runt_d      = '0;
            over_d      = '0;
            error_d     = '0;
            rx_bytes_d  = '0;
            last_size_d = '0;
            ts_sec_d    = '0;
            ts_nsec_d   = '0;
            last_gap_d  = '0;
            min_gap_d   = GAP_MAX;
            seen_d      = 1'b0;
        end else if (pend_q) begin
            fv_d = 1'b1;
            if (pend_size_q) begin
                last_size_d = pend_len_q;
            end
            case (pend_cls_q)
                CLS_GOOD: begin
                    good_d     = good_q + 32'd1;
                    rx_bytes_d = rx_bytes_q + 64'(pend_len_q);
                end
                CLS_BAD_FCS:  bad_fcs_d = bad_fcs_q + 32'd1;
                CLS_RUNT:     runt_d    = runt_q + 32'd1;
                CLS_OVERSIZE: over_d    = over_q + 32'd1;
                default:      error_d   = error_q + 32'd1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q         <= '0;
            dv_q        <= 1'b0;
            er_q        <= 1'b0;
            in_vld_q    <= 1'b0;
            dvp_q       <= 1'b1;
            state_q     <= ST_IDLE;
            len_q       <= '0;
            crc_q       <= CRC_INIT;
            err_q       <= 1'b0;
            gap_q       <= '0;
            seen_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_cls_q  <= CLS_GOOD;
            pend_len_q  <= '0;
            pend_size_q <= 1'b0;
            good_q      <= '0;
            bad_fcs_q   <= '0;
            runt_q      <= '0;
            over_q      <= '0;
            error_q     <= '0;
            rx_bytes_q  <= '0;
            last_size_q <= '0;
            ts_sec_q    <= '0;
            ts_nsec_q   <= '0;
            last_gap_q  <= '0;
            min_gap_q   <= GAP_MAX;
            fv_q        <= 1'b0;
        end else begin
            d_q         <= d_d;
            dv_q        <= dv_d;
            er_q        <= er_d;
            in_vld_q    <= in_vld_d;
            dvp_q       <= dvp_d;
            state_q     <= state_d;
            len_q       <= len_d;
            crc_q       <= crc_d;
            err_q       <= err_d;
            gap_q       <= gap_d;
            seen_q      <= seen_d;
            pend_q      <= pend_d;
            pend_cls_q  <= pend_cls_d;
            pend_len_q  <= pend_len_d;
            pend_size_q <= pend_size_d;
            good_q      <= good_d;
            bad_fcs_q   <= bad_fcs_d;
            runt_q      <= runt_d;
            over_q      <= over_d;
            error_q     <= error_d;
            rx_bytes_q  <= rx_bytes_d;
            last_size_q <= last_size_d;
            ts_sec_q    <= ts_sec_d;
            ts_nsec_q   <= ts_nsec_d;
            last_gap_q  <= last_gap_d;
            min_gap_q   <= min_gap_d;
            fv_q        <= fv_d;
        end
    end

    assign good_frames     = good_q;
    assign bad_fcs_frames  = bad_fcs_q;
    assign runt_frames     = runt_q;
    assign oversize_frames = over_q;
    assign error_frames    = error_q;
    assign rx_bytes        = rx_bytes_q;
    assign last_frame_size = last_size_q;
    assign last_ts_sec     = ts_sec_q;
    assign last_ts_nsec    = ts_nsec_q;
    assign last_gap        = last_gap_q;
    assign min_gap         = min_gap_q;
    assign frame_valid     = fv_q;

endmodule

// File: tb/tb_traffic_analyzer_gmii.sv
// Directed plus randomized frame traffic for traffic_analyzer_gmii, checked against a
// frame-level model of the statistics.
module tb_traffic_analyzer_gmii;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] sec;
    logic [29:0] nsec;
    logic        enable;
    logic        clear;
    logic [31:0] good_frames, bad_fcs_frames, runt_frames, oversize_frames, error_frames;
    logic [63:0] rx_bytes;
    logic [15:0] last_frame_size;
    logic [47:0] last_ts_sec;
    logic [29:0] last_ts_nsec;
    logic [31:0] last_gap, min_gap;
    logic        frame_valid;

    traffic_analyzer_gmii_if gi ();

    always #5 clk = ~clk;

    traffic_analyzer_gmii #(
        .C_MIN_FRAME_SIZE (64),
        .C_MAX_FRAME_SIZE (1518)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .gmii            (gi),
        .sec             (sec),
        .nsec            (nsec),
        .enable          (enable),
        .clear           (clear),
        .good_frames     (good_frames),
        .bad_fcs_frames  (bad_fcs_frames),
        .runt_frames     (runt_frames),
        .oversize_frames (oversize_frames),
        .error_frames    (error_frames),
        .rx_bytes        (rx_bytes),
        .last_frame_size (last_frame_size),
        .last_ts_sec     (last_ts_sec),
        .last_ts_nsec    (last_ts_nsec),
        .last_gap        (last_gap),
        .min_gap         (min_gap),
        .frame_valid     (frame_valid)
    );

    int vectors = 0;
    int miscompares = 0;

    // frame-level reference state
    logic [31:0] m_good, m_bad, m_runt, m_over, m_err;
    logic [63:0] m_rx;
    logic [15:0] m_size;
    logic [47:0] m_sec;
    logic [29:0] m_nsec;
    logic [31:0] m_last_gap, m_min_gap;
    bit          m_seen;
    int          idle_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_good = 0; m_bad = 0; m_runt = 0; m_over = 0; m_err = 0;
        m_rx = 0; m_size = 0; m_sec = 0; m_nsec = 0;
        m_last_gap = 0; m_min_gap = 32'hFFFFFFFF; m_seen = 0;
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 8; k++) begin
            r = (r[0] ^ b[k]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    task automatic check_all(input string pfx);
        chk({pfx, ".good"},     64'(good_frames),     64'(m_good));
        chk({pfx, ".bad_fcs"},  64'(bad_fcs_frames),  64'(m_bad));
        chk({pfx, ".runt"},     64'(runt_frames),     64'(m_runt));
        chk({pfx, ".oversize"}, 64'(oversize_frames), 64'(m_over));
        chk({pfx, ".error"},    64'(error_frames),    64'(m_err));
        chk({pfx, ".rx_bytes"}, rx_bytes,             m_rx);
        chk({pfx, ".size"},     64'(last_frame_size), 64'(m_size));
        chk({pfx, ".ts_sec"},   64'(last_ts_sec),     64'(m_sec));
        chk({pfx, ".ts_nsec"},  64'(last_ts_nsec),    64'(m_nsec));
        chk({pfx, ".last_gap"}, 64'(last_gap),        64'(m_last_gap));
        chk({pfx, ".min_gap"},  64'(min_gap),         64'(m_min_gap));
    endtask

    task automatic drive_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            gi.gmii_dv = 1'b0; gi.gmii_d = 8'h00; gi.gmii_er = 1'b0;
        end
        idle_cnt += n;
    endtask

    // Sends preamble, SFD, n_data bytes and FCS, then 5 idle cycles while checking the
    // statistics update exactly 2 cycles after the edge that samples dv low.
    task automatic send_frame(input string tag, input int n_data, input bit incr,
                              input bit bad_fcs, input int er_pos, input bit en,
                              input bit en_drop, input bit clr_mid, input bit clr_end,
                              input int rst_pos);
        logic [7:0]  frm[$];
        logic [31:0] c;
        int          len;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n_data; i++) begin
            frm.push_back(incr ? 8'(i) : 8'($urandom));
            c = crc_step(c, frm[i]);
        end
        c = ~c;
        frm.push_back(c[7:0]); frm.push_back(c[15:8]);
        frm.push_back(c[23:16]); frm.push_back(c[31:24]);
        if (bad_fcs) frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h01;
        len = frm.size();

        @(negedge clk);
        sec    = 48'({$urandom(), $urandom()});
        nsec   = 30'($urandom());
        enable = en;
        if (en) begin
            if (m_seen) begin
                m_last_gap = 32'(idle_cnt);
                if (32'(idle_cnt) < m_min_gap) m_min_gap = 32'(idle_cnt);
            end
            m_seen = 1;
            m_sec  = sec;
            m_nsec = nsec;
        end
        idle_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            gi.gmii_dv = 1'b1;
            gi.gmii_d  = (i == 7) ? 8'hD5 : 8'h55;
            gi.gmii_er = 1'b0;
        end
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            gi.gmii_d  = frm[i];
            gi.gmii_er = (i == er_pos);
            if (en_drop && i == 5) enable = 1'b0;
            clear = (clr_mid && i == 20);
            rst   = (i == rst_pos);
            if (clr_mid && i == 20) model_clear();
            if (i == rst_pos) begin
                model_clear();
                idle_cnt = 0;
            end
        end
        @(negedge clk);
        gi.gmii_dv = 1'b0; gi.gmii_d = 8'h00; gi.gmii_er = 1'b0;
        clear = 1'b0; rst = 1'b0; enable = 1'b1;
        if (en && rst_pos < 0) begin
            if (clr_end) begin
                model_clear();
            end else begin
                m_size = 16'(len);
                if (er_pos >= 0 && er_pos < len) m_err++;
                else if (len < 64)               m_runt++;
                else if (len > 1518)             m_over++;
                else if (bad_fcs)                m_bad++;
                else begin
                    m_good++;
                    m_rx += 64'(len);
                end
            end
        end
        @(negedge clk);
        chk({tag, ".fv_early1"}, 64'(frame_valid), 64'd0);
        @(negedge clk);
        chk({tag, ".fv_early2"}, 64'(frame_valid), 64'd0);
        clear = clr_end;
        @(negedge clk);
        clear = 1'b0;
        if (!clr_end) chk({tag, ".fv"}, 64'(frame_valid), 64'(en && rst_pos < 0));
        check_all(tag);
        @(negedge clk);
        chk({tag, ".fv_late"}, 64'(frame_valid), 64'd0);
        idle_cnt += 5;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; clear = 1'b0; sec = '0; nsec = '0;
        gi.gmii_dv = 1'b0; gi.gmii_d = 8'h00; gi.gmii_er = 1'b0;
        idle_cnt = 0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("reset.fv", 64'(frame_valid), 64'd0);
        check_all("reset");
        rst = 1'b0;
        drive_idle(10);

        send_frame("good64",   60,   1, 0, -1, 1, 0, 0, 0, -1); drive_idle(7);
        send_frame("badfcs",   60,   1, 1, -1, 1, 0, 0, 0, -1); drive_idle(7);
        send_frame("gmii_er",  60,   1, 0, 10, 1, 0, 0, 0, -1); drive_idle(7);
        send_frame("runt20",   16,   0, 0, -1, 1, 0, 0, 0, -1); drive_idle(7);
        send_frame("runt63",   59,   0, 0, -1, 1, 0, 0, 0, -1); drive_idle(7);
        send_frame("max1518",  1514, 0, 0, -1, 1, 0, 0, 0, -1); drive_idle(7);
        send_frame("over1519", 1515, 0, 0, -1, 1, 0, 0, 0, -1); drive_idle(7);

        // three good frames, 12 then 20 idle cycles apart; the second drops enable mid-frame
        send_frame("gap_a", 60, 0, 0, -1, 1, 0, 0, 0, -1); drive_idle(7);
        send_frame("gap_b", 60, 0, 0, -1, 1, 1, 0, 0, -1); drive_idle(15);
        send_frame("gap_c", 60, 0, 0, -1, 1, 0, 0, 0, -1); drive_idle(7);

        send_frame("rst_mid",   60, 0, 0, -1, 1, 0, 0, 0, 30); drive_idle(7);
        send_frame("after_rst", 60, 0, 0, -1, 1, 0, 0, 0, -1); drive_idle(9);

        for (int n = 0; n < 30; n++) begin
            int nd;
            nd = $urandom_range(16, 90);
            send_frame("rand", nd, 0, ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 4) == 0) ? $urandom_range(0, nd - 1) : -1,
                       1, ($urandom_range(0, 3) == 0), 0, 0, -1);
            drive_idle($urandom_range(7, 25));
        end

        send_frame("disabled",  60, 0, 0, -1, 0, 0, 0, 0, -1); drive_idle(7);
        send_frame("clear_mid", 60, 0, 0, -1, 1, 0, 1, 0, -1); drive_idle(7);
        send_frame("clear_end", 60, 0, 0, -1, 1, 0, 0, 1, -1); drive_idle(7);
        send_frame("post_clr",  60, 0, 0, -1, 1, 0, 0, 0, -1); drive_idle(13);
        send_frame("post_clr2", 70, 0, 0, -1, 1, 0, 0, 0, -1); drive_idle(7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
